// File: rtl/cpu_pkg.sv
// Shared CPU front-end types: datapath width, reset vector, fetch FSM states
// and the instruction-buffer entry layout.
package cpu_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH,
    WAIT,
    DRAIN
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch unit (master)
// and the memory (slave).
interface fetch_unit_if #(
  parameter int XLEN = cpu_pkg::XLEN
) ();

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ready;
  logic            imem_rvalid;
  logic [XLEN-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rvalid,
    output imem_rdata
  );

endinterface

// File: rtl/fetch_fifo.sv
// Circular instruction buffer of fetch_entry_t with push/pop/flush; the head
// entry is presented combinationally from the read pointer.
module fetch_fifo import cpu_pkg::*; #(
  parameter int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  fetch_entry_t     push_entry,
  input  logic             pop,
  output logic [CNT_W-1:0] count,
  output fetch_entry_t     head
);

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             empty;
  logic             full;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  // A push into a full buffer is only legal when the head leaves the same cycle.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_entry;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      if (do_push && !do_pop) begin
        count <= count + 1'b1;
      end else if (do_pop && !do_push) begin
        count <= count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Sequential instruction fetch with a single outstanding memory request,
// redirect handling and a small decoupling buffer toward decode.
module fetch_unit import cpu_pkg::*; #(
  parameter int              XLEN     = cpu_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = cpu_pkg::RESET_PC,
  parameter int              DEPTH    = 2
) (
  input  logic            clk,
  input  logic            reset,
  fetch_unit_if.master    imem,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] instr_data,
  output logic [XLEN-1:0] instr_pc,
  output logic [XLEN-1:0] instr_pc8
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  fetch_state_t     state;
  logic [XLEN-1:0]  fetch_pc;
  logic [XLEN-1:0]  req_pc;
  logic             pending;
  logic [CNT_W-1:0] count;
  fetch_entry_t     head;
  fetch_entry_t     push_entry;
  logic             req;
  logic             accept;
  logic             push;
  logic             pop_fire;

  assign instr_valid = (count != '0);
  assign pop_fire    = instr_valid && instr_ready && !redirect_valid;
  assign push        = (state == WAIT) && imem.imem_rvalid && !redirect_valid;
  assign push_entry  = '{pc: req_pc, instr: imem.imem_rdata};
  assign accept      = req && imem.imem_ready;

  // Back-to-back requests in WAIT count the slot freed by a same-cycle pop.
  always_comb begin
    req = 1'b0;
    if (reset && !redirect_valid) begin
      unique case (state)
        FETCH:   req = (int'(count) + int'(pending)) < DEPTH;
        WAIT:    req = imem.imem_rvalid && ((int'(count) + 1 - int'(pop_fire)) < DEPTH);
        default: req = 1'b0;
      endcase
    end
  end

  assign imem.imem_req  = req;
  assign imem.imem_addr = fetch_pc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= FETCH;
      fetch_pc <= RESET_PC;
      req_pc   <= '0;
      pending  <= 1'b0;
    end else if (redirect_valid) begin
      fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
      // A response landing with the redirect retires the stale request, even in DRAIN.
      if (state != FETCH && !imem.imem_rvalid) begin
        state <= DRAIN;
      end else begin
        state   <= FETCH;
        pending <= 1'b0;
      end
    end else begin
      unique case (state)
        FETCH: begin
          if (accept) begin
            req_pc   <= fetch_pc;
            fetch_pc <= fetch_pc + XLEN'(4);
            state    <= WAIT;
            pending  <= 1'b1;
          end
        end
        WAIT: begin
          if (imem.imem_rvalid) begin
            if (accept) begin
              req_pc   <= fetch_pc;
              fetch_pc <= fetch_pc + XLEN'(4);
            end else begin
              state   <= FETCH;
              pending <= 1'b0;
            end
          end
        end
        default: begin
          if (imem.imem_rvalid) begin
            state   <= FETCH;
            pending <= 1'b0;
          end
        end
      endcase
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .flush      (redirect_valid),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop_fire),
    .count      (count),
    .head       (head)
  );

  assign instr_data = head.instr;
  assign instr_pc   = head.pc;
  assign instr_pc8  = head.pc + XLEN'(8);

endmodule
